// File: rtl/front_linebuffer_pp.sv
// Ping-pong line buffer for the sprite/front layer: one bank is written at an
// auto-incrementing X while the other is scanned out, swapping on each lt rise.
module front_linebuffer_pp #(
  parameter int unsigned      DW            = 8,
  parameter int unsigned      AW            = 9,
  parameter int unsigned      TW            = 3,
  parameter int unsigned      CLEAR_ON_READ = 1,
  parameter logic [DW-1:0]    CLEAR_VAL     = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_cen,
  input  logic          wr_load,
  input  logic [AW-1:0] wr_start,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_cen,
  input  logic          rd_load,
  input  logic [AW-1:0] rd_start,
  input  logic          rd_dir,
  input  logic          lt,
  output logic [DW-1:0] rd_data,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr
);

  localparam int unsigned   DEPTH    = 2 ** (AW + 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];

  logic          lt_q;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          lt_rise;
  logic          transparent;
  logic          wr_we;
  logic          clr_we;
  logic [AW:0]   wr_idx;
  logic [AW:0]   rd_idx;

  // Both ports use the pre-toggle bank; the swap only lands at the clock edge.
  assign wr_idx      = {wr_bank_q, wr_addr_q};
  assign rd_idx      = {~wr_bank_q, rd_addr_q};
  assign transparent = &wr_data[TW-1:0];
  assign lt_rise     = lt & ~lt_q;

  always_comb begin
    wr_bank_d = wr_bank_q ^ lt_rise;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wr_we     = 1'b0;
    clr_we    = 1'b0;

    if (wr_cen) begin
      if (wr_load) begin
        wr_addr_d = wr_start;
      end else begin
        wr_we     = ~transparent;
        wr_addr_d = wr_addr_q + ADDR_ONE;
      end
    end

    if (rd_cen) begin
      if (rd_load) begin
        rd_addr_d = rd_start;
      end else begin
        rd_data_d = mem[rd_idx];
        clr_we    = (CLEAR_ON_READ != 0);
        rd_addr_d = rd_dir ? (rd_addr_q + ADDR_ONE) : (rd_addr_q - ADDR_ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_q      <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= CLEAR_VAL;
    end else begin
      lt_q      <= lt;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Contents are not reset, but a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_we) begin
        mem[wr_idx] <= wr_data;
      end
      if (clr_we) begin
        mem[rd_idx] <= CLEAR_VAL;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign wr_bank = wr_bank_q;
  assign wr_addr = wr_addr_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_front_linebuffer_pp.sv
// Directed bench for front_linebuffer_pp: one clear-on-read instance and one
// keep-data instance share the same stimulus.
module tb_front_linebuffer_pp;

  logic       clk;
  logic       rst;
  logic       wr_cen;
  logic       wr_load;
  logic [8:0] wr_start;
  logic [7:0] wr_data;
  logic       rd_cen;
  logic       rd_load;
  logic [8:0] rd_start;
  logic       rd_dir;
  logic       lt;

  logic [7:0] rd_data,  nc_rd_data;
  logic       wr_bank,  nc_wr_bank;
  logic [8:0] wr_addr,  nc_wr_addr;
  logic [8:0] rd_addr,  nc_rd_addr;

  int n_checks = 0;
  int n_pass   = 0;

  front_linebuffer_pp dut (
    .clk(clk), .rst(rst),
    .wr_cen(wr_cen), .wr_load(wr_load), .wr_start(wr_start), .wr_data(wr_data),
    .rd_cen(rd_cen), .rd_load(rd_load), .rd_start(rd_start), .rd_dir(rd_dir),
    .lt(lt),
    .rd_data(rd_data), .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_addr(rd_addr)
  );

  front_linebuffer_pp #(.CLEAR_ON_READ(0)) dut_nc (
    .clk(clk), .rst(rst),
    .wr_cen(wr_cen), .wr_load(wr_load), .wr_start(wr_start), .wr_data(wr_data),
    .rd_cen(rd_cen), .rd_load(rd_load), .rd_start(rd_start), .rd_dir(rd_dir),
    .lt(lt),
    .rd_data(nc_rd_data), .wr_bank(nc_wr_bank), .wr_addr(nc_wr_addr), .rd_addr(nc_rd_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ld(input logic [8:0] a);
    wr_cen = 1'b1; wr_load = 1'b1; wr_start = a;
    cycle();
    wr_cen = 1'b0; wr_load = 1'b0;
  endtask

  task automatic wr_px(input logic [7:0] d);
    wr_cen = 1'b1; wr_load = 1'b0; wr_data = d;
    cycle();
    wr_cen = 1'b0;
  endtask

  task automatic rd_ld(input logic [8:0] a);
    rd_cen = 1'b1; rd_load = 1'b1; rd_start = a;
    cycle();
    rd_cen = 1'b0; rd_load = 1'b0;
  endtask

  task automatic rd_px(input logic dir);
    rd_cen = 1'b1; rd_load = 1'b0; rd_dir = dir;
    cycle();
    rd_cen = 1'b0;
  endtask

  task automatic swap();
    lt = 1'b1;
    cycle();
    lt = 1'b0;
    cycle();
  endtask

  task automatic write_line();
    logic [7:0] px [4];
    px = '{8'h11, 8'h22, 8'h07, 8'h33};
    wr_ld(9'h010);
    for (int i = 0; i < 4; i++) wr_px(px[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_cen = 1'b0; wr_load = 1'b0; wr_start = '0; wr_data = '0;
    rd_cen = 1'b0; rd_load = 1'b0; rd_start = '0; rd_dir = 1'b1; lt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rd_data !== 8'hFF) $display("[TB] FAIL reset_rd_data got %h want ff", rd_data);
    else n_pass++;
    n_checks++;
    if (wr_bank !== 1'b0) $display("[TB] FAIL reset_wr_bank got %b want 0", wr_bank);
    else n_pass++;
    n_checks++;
    if (wr_addr !== 9'h000 || rd_addr !== 9'h000)
      $display("[TB] FAIL reset_addr got wr=%h rd=%h want 000/000", wr_addr, rd_addr);
    else n_pass++;
    n_checks++;
    if (nc_rd_data !== 8'hFF) $display("[TB] FAIL reset_nc_rd_data got %h want ff", nc_rd_data);
    else n_pass++;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_swap();
    // Blank 0x010..0x013 of bank 1 (read bank after reset), then of bank 0.
    rd_ld(9'h010);
    for (int i = 0; i < 4; i++) rd_px(1'b1);
    lt = 1'b1;
    cycle();
    n_checks++;
    if (wr_bank !== 1'b1) $display("[TB] FAIL swap_toggle got %b want 1", wr_bank);
    else n_pass++;
    cycle();
    n_checks++;
    if (wr_bank !== 1'b1) $display("[TB] FAIL swap_level_hold got %b want 1", wr_bank);
    else n_pass++;
    lt = 1'b0;
    cycle();
    rd_ld(9'h010);
    for (int i = 0; i < 4; i++) rd_px(1'b1);
  endtask

  task automatic test_write_read();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'hFF, 8'h33};
    write_line();
    n_checks++;
    if (wr_addr !== 9'h014) $display("[TB] FAIL wr_addr_after_line got %h want 014", wr_addr);
    else n_pass++;
    swap();
    n_checks++;
    if (wr_bank !== 1'b0) $display("[TB] FAIL swap_back got %b want 0", wr_bank);
    else n_pass++;
    rd_ld(9'h010);
    for (int i = 0; i < 4; i++) begin
      rd_px(1'b1);
      n_checks++;
      if (rd_data !== exp[i]) $display("[TB] FAIL read_up[%0d] got %h want %h", i, rd_data, exp[i]);
      else n_pass++;
      if (i != 2) begin
        n_checks++;
        if (nc_rd_data !== exp[i])
          $display("[TB] FAIL nc_read_up[%0d] got %h want %h", i, nc_rd_data, exp[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (rd_addr !== 9'h014) $display("[TB] FAIL rd_addr_after_up got %h want 014", rd_addr);
    else n_pass++;
  endtask

  task automatic test_flip();
    logic [7:0] exp [4];
    exp = '{8'h33, 8'hFF, 8'h22, 8'h11};
    write_line();
    swap();
    rd_ld(9'h013);
    n_checks++;
    if (rd_data !== 8'h33) $display("[TB] FAIL rd_load_holds got %h want 33", rd_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_px(1'b0);
      n_checks++;
      if (rd_data !== exp[i]) $display("[TB] FAIL read_down[%0d] got %h want %h", i, rd_data, exp[i]);
      else n_pass++;
      if (i != 1) begin
        n_checks++;
        if (nc_rd_data !== exp[i])
          $display("[TB] FAIL nc_read_down[%0d] got %h want %h", i, nc_rd_data, exp[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (rd_addr !== 9'h00F) $display("[TB] FAIL rd_addr_after_down got %h want 00f", rd_addr);
    else n_pass++;
  endtask

  task automatic test_clear_on_read();
    logic [7:0] nc_exp [4];
    nc_exp = '{8'h11, 8'h22, 8'hFF, 8'h33};
    rd_ld(9'h010);
    for (int i = 0; i < 4; i++) begin
      rd_px(1'b1);
      n_checks++;
      if (rd_data !== 8'hFF) $display("[TB] FAIL cleared[%0d] got %h want ff", i, rd_data);
      else n_pass++;
      if (i != 2) begin
        n_checks++;
        if (nc_rd_data !== nc_exp[i])
          $display("[TB] FAIL nc_kept[%0d] got %h want %h", i, nc_rd_data, nc_exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    wr_ld(9'h1FF);
    wr_px(8'h5A);
    wr_px(8'hA5);
    n_checks++;
    if (wr_addr !== 9'h001) $display("[TB] FAIL wr_wrap got %h want 001", wr_addr);
    else n_pass++;
    swap();
    rd_ld(9'h1FF);
    rd_px(1'b1);
    n_checks++;
    if (rd_data !== 8'h5A) $display("[TB] FAIL wrap_px0 got %h want 5a", rd_data);
    else n_pass++;
    rd_px(1'b1);
    n_checks++;
    if (rd_data !== 8'hA5) $display("[TB] FAIL wrap_px1 got %h want a5", rd_data);
    else n_pass++;
    n_checks++;
    if (rd_addr !== 9'h001) $display("[TB] FAIL rd_wrap_up got %h want 001", rd_addr);
    else n_pass++;
    rd_ld(9'h000);
    rd_px(1'b0);
    n_checks++;
    if (rd_addr !== 9'h1FF) $display("[TB] FAIL rd_wrap_down got %h want 1ff", rd_addr);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'hFF || nc_rd_data !== 8'hA5)
      $display("[TB] FAIL wrap_reread got %h/%h want ff/a5", rd_data, nc_rd_data);
    else n_pass++;
  endtask

  task automatic test_coincidence();
    wr_ld(9'h030);
    wr_px(8'h61);
    wr_px(8'h62);
    swap();
    rd_ld(9'h030);
    wr_ld(9'h040);
    lt = 1'b1;
    wr_cen = 1'b1; wr_load = 1'b0; wr_data = 8'h71;
    rd_cen = 1'b1; rd_load = 1'b0; rd_dir = 1'b1;
    cycle();
    lt = 1'b0; wr_cen = 1'b0; rd_cen = 1'b0;
    n_checks++;
    if (wr_bank !== 1'b0) $display("[TB] FAIL coin_swap got %b want 0", wr_bank);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'h61) $display("[TB] FAIL coin_read_old_bank got %h want 61", rd_data);
    else n_pass++;
    n_checks++;
    if (wr_addr !== 9'h041 || rd_addr !== 9'h031)
      $display("[TB] FAIL coin_addr got wr=%h rd=%h want 041/031", wr_addr, rd_addr);
    else n_pass++;
    cycle();
    rd_ld(9'h040);
    rd_px(1'b1);
    n_checks++;
    if (rd_data !== 8'h71) $display("[TB] FAIL coin_write_kept got %h want 71", rd_data);
    else n_pass++;
    swap();
    rd_ld(9'h031);
    rd_px(1'b1);
    n_checks++;
    if (rd_data !== 8'h62) $display("[TB] FAIL coin_rest_of_line got %h want 62", rd_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_swap();
    test_write_read();
    test_flip();
    test_clear_on_read();
    test_wrap();
    test_coincidence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
